// File: rtl/k12_pkg.sv
// Shared constants and FSM encoding for the K12 nonce dispatcher.
// Build option K12_HASH_COUNTER_EN is consumed by k12_nonce_dispatcher.
package k12_pkg;

  localparam int STATE_W       = 1600;
  localparam int HASH_W        = 256;
  localparam int NONCE_W       = 32;
  localparam int TARGET_W      = 64;
  localparam int NONCE_OFS_DEF = 312;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] ARM    = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] CHECK  = 3'd5;
  localparam logic [2:0] REPORT = 3'd6;
  localparam logic [2:0] NEXT   = 3'd7;

endpackage

// File: rtl/k12_target_cmp.sv
// Unsigned compare of the top 64 hash bits against the job target.
// A hit means the hash difficulty word is strictly below the target.
module k12_target_cmp
  import k12_pkg::*;
(
  input  logic [HASH_W-1:0]   hash,
  input  logic [TARGET_W-1:0] target,
  output logic                hit
);

  assign hit = hash[HASH_W-1 -: TARGET_W] < target;

endmodule

// File: rtl/k12_nonce_dispatcher.sv
// Walks a nonce range through one K12 core and reports target hits.
// Define K12_HASH_COUNTER_EN to add the saturating hash_count output.
module k12_nonce_dispatcher
  import k12_pkg::*;
#(
  parameter int NONCE_OFS = NONCE_OFS_DEF,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [STATE_W-1:0]  job_blob,
  input  logic [NONCE_W-1:0]  job_nonce0,
  input  logic [NONCE_W-1:0]  job_count,
  input  logic [TARGET_W-1:0] job_target,
  input  logic                abort,
  output logic                core_start,
  output logic [STATE_W-1:0]  core_data,
  input  logic [HASH_W-1:0]   core_hash,
  input  logic                core_valid,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NONCE_W-1:0]  res_nonce,
  output logic [HASH_W-1:0]   res_hash,
  output logic                job_done,
`ifdef K12_HASH_COUNTER_EN
  output logic [47:0]         hash_count,
`endif
  output logic                err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]          state;
  logic [STATE_W-1:0]  blob_q;
  logic [NONCE_W-1:0]  nonce_q;
  logic [NONCE_W-1:0]  rem_q;
  logic [TARGET_W-1:0] target_q;
  logic [HASH_W-1:0]   hash_q;
  logic [CW-1:0]       wcnt;
  logic                abort_pend;
  logic                done_q;
  logic                hit;
  logic [STATE_W-1:0]  data_next;

  k12_target_cmp u_cmp (
    .hash   (hash_q),
    .target (target_q),
    .hit    (hit)
  );

  always_comb begin
    data_next = blob_q;
    data_next[NONCE_OFS +: NONCE_W] = nonce_q;
  end

  assign job_ready  = rst && (state == IDLE);
  assign core_start = (state == START);
  assign res_valid  = (state == REPORT);
  assign job_done   = done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      blob_q      <= '0;
      nonce_q     <= '0;
      rem_q       <= '0;
      target_q    <= '0;
      hash_q      <= '0;
      wcnt        <= '0;
      abort_pend  <= 1'b0;
      done_q      <= 1'b0;
      err_timeout <= 1'b0;
      core_data   <= '0;
      res_nonce   <= '0;
      res_hash    <= '0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (job_valid) begin
          blob_q      <= job_blob;
          nonce_q     <= job_nonce0;
          rem_q       <= job_count;
          target_q    <= job_target;
          err_timeout <= 1'b0;
          abort_pend  <= 1'b0;
          if (job_count == '0) done_q <= 1'b1;
          else                 state  <= LOAD;
        end
      end else if (abort && state != WAIT) begin
        done_q <= 1'b1;
        state  <= IDLE;
      end else begin
        unique case (state)
          LOAD: begin
            core_data <= data_next;
            state     <= START;
          end
          START: state <= ARM;
          ARM: begin
            wcnt  <= '0;
            state <= WAIT;
          end
          WAIT: begin
            if (abort) abort_pend <= 1'b1;
            // An abort seen in WAIT only lands once the core has answered
            if (core_valid) begin
              if (abort_pend || abort) begin
                done_q <= 1'b1;
                state  <= IDLE;
              end else begin
                hash_q <= core_hash;
                state  <= CHECK;
              end
            end else if (wcnt == CW'(TIMEOUT - 1)) begin
              err_timeout <= 1'b1;
              done_q      <= 1'b1;
              state       <= IDLE;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
          CHECK: begin
            if (hit) begin
              res_nonce <= nonce_q;
              res_hash  <= hash_q;
              state     <= REPORT;
            end else begin
              state <= NEXT;
            end
          end
          REPORT: if (res_ready) state <= NEXT;
          NEXT: begin
            rem_q   <= rem_q - 1'b1;
            nonce_q <= nonce_q + 1'b1;
            if (rem_q == NONCE_W'(1)) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef K12_HASH_COUNTER_EN
  logic check_entry;

  assign check_entry = rst && state == WAIT && core_valid &&
                       !abort_pend && !abort;

  always_ff @(posedge clk) begin
    if (!rst)
      hash_count <= '0;
    else if (check_entry && hash_count != '1)
      hash_count <= hash_count + 1'b1;
  end
`endif

endmodule

// File: doc/k12_nonce_dispatcher.md
Name: k12_nonce_dispatcher

Overview:
Work initiator for the K12 hash core. Accepts a mining job (1600-bit pre-padded state template, nonce range, 64-bit target) and inserts each nonce into the template. It pulses the core's start, waits for the core's valid, and compares the hash against the target. Hits go out on a result handshake; job completion is reported with a done pulse. Sits between the host job interface and one K12 hash instance.

Parameters:
NONCE_OFS, 312, bit offset of the 32-bit little-endian nonce field in the state template.
TIMEOUT, 64, maximum cycles to wait for core valid before flagging an error.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-low reset (0 = reset).
job_valid  in  1  job offered.
job_ready  out  1  dispatcher can accept a job (high only in IDLE).
job_blob  in  1600  state template.
job_nonce0  in  32  first nonce.
job_count  in  32  number of nonces to try (0 = none).
job_target  in  64  hit when hash[255:192] < target (unsigned).
abort  in  1  cancel current job.
core_start  out  1  one-cycle start pulse to the hash core.
core_data  out  1600  template with nonce inserted.
core_hash  in  256  core hash output.
core_valid  in  1  core result valid (level; cleared by core on start).
res_valid  out  1  hit available.
res_ready  in  1  hit consumed.
res_nonce  out  32  hitting nonce.
res_hash  out  256  hitting hash.
job_done  out  1  one-cycle pulse: range exhausted or aborted.
err_timeout  out  1  sticky; set on core timeout, cleared by reset or next job accept.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE. job_ready=0 during reset, then 1 in IDLE. core_start=0, res_valid=0, job_done=0, err_timeout=0. core_data, res_nonce and res_hash are 0.
- IDLE: job_ready=1. job_valid&job_ready latches blob, nonce0, count and target, clears err_timeout, then goes to LOAD. If count=0: job_done pulses next cycle and the state returns to IDLE.
- LOAD: core_data = blob with bits [NONCE_OFS+31:NONCE_OFS] = current nonce; then START.
- START: core_start=1 for exactly one cycle; then ARM.
- ARM: one cycle in which core_valid is ignored (absorbs a stale level from the previous hash); then WAIT. The wait counter is cleared.
- WAIT: on core_valid=1, register core_hash and go to CHECK. If the wait counter reaches TIMEOUT: set err_timeout, pulse job_done, go to IDLE.
- CHECK: if hash[255:192] < target, go to REPORT. Otherwise go to NEXT.
- REPORT: res_valid=1 with res_nonce and res_hash stable until res_ready; the transfer occurs on the cycle where both are high. No hits are dropped; the dispatcher stalls while a hit is pending. After the transfer, go to NEXT.
- NEXT: decrement remaining and increment nonce. Nonce wraps 0xFFFFFFFF to 0 with no flag. If remaining becomes 0: job_done pulse, IDLE. Otherwise LOAD.
- Latency per nonce with no hit: LOAD+START+ARM+core(13)+CHECK+NEXT ≈ 18 cycles.
- abort has priority over every transition except reset:
  - in WAIT, it sets a pending flag; the core result is discarded when valid arrives.
  - in any other non-IDLE state, it takes effect the same cycle: res_valid drops on the next edge, job_done pulses, state goes to IDLE.
  - in IDLE it is ignored.
- Reset mid-job discards everything; core_start is guaranteed low in the cycle after reset.
- job_valid outside IDLE is ignored (job_ready=0).

Optional Feature:
K12_HASH_COUNTER_EN. Defined: adds output port hash_count [47:0], incremented on each CHECK entry, saturating at all-ones, cleared only by reset. Undefined: port and counter absent; all other behaviour is identical.

Decomposition:
- Package k12_pkg holds: the state encoding (IDLE, LOAD, START, ARM, WAIT, CHECK, REPORT, NEXT), STATE_W=1600, HASH_W=256, NONCE_W=32, TARGET_W=64, and the NONCE_OFS default.
- One natural sub-module, k12_target_cmp: combinational 64-bit unsigned less-than on hash[255:192] vs target, registered by the dispatcher in CHECK.

Test Plan:
- Reset with rst=0 for 3 cycles -> all outputs 0, state IDLE; job_ready=1 in the first cycle after rst=1.
- Job count=4, nonce0=0x00000010, target=0 -> four core_start pulses with nonces 0x10..0x13 at bits [343:312]; no res_valid; job_done one cycle after the 4th CHECK.
- Job count=2, target=0xFFFFFFFFFFFFFFFF, res_ready held 0 for 20 cycles -> res_valid held with nonce0 and its hash stable; no second core_start until after the handshake; 2 hits total.
- Job nonce0=0xFFFFFFFF, count=2 -> nonces 0xFFFFFFFF then 0x00000000; job_done after the 2nd.
- core_valid stuck 0 -> err_timeout=1 and job_done pulse TIMEOUT cycles after ARM; the next job accept clears err_timeout.
- abort during WAIT with a later hit pending -> no res_valid, job_done pulse after core_valid, then IDLE. Stale core_valid=1 held through START/ARM -> not treated as a result.
